// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit and the hazard
// logic that stalls HI/LO consumers while the unit is busy.
package md_defs;

    // Operation select carried from the E stage.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Sequencer states of the unit.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Default latencies, in busy cycles.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // SPECIAL-opcode funct codes of every HI/LO-using instruction.
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    // True for any SPECIAL funct that touches HI/LO (hazard md-stall term).
    function automatic logic is_md_funct(input logic [5:0] funct);
        case (funct)
            FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // True for the two divide encodings.
    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // True for the two signed encodings.
    function automatic logic is_signed_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage command / HI-LO result bundle between the pipeline and the unit.
interface mult_div_unit_if;
    import md_defs::*;

    logic        start;
    md_op_e      md_op;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline side: issues commands, reads HI/LO and busy.
    modport master (
        output start, md_op, wr_hi, wr_lo, A, B,
        input  busy, HI, LO
    );

    // Unit side.
    modport slave (
        input  start, md_op, wr_hi, wr_lo, A, B,
        output busy, HI, LO
    );

endinterface

// File: rtl/mult_div_unit_compute.sv
// Combinational datapath: full 64-bit product or quotient/remainder pair
// for the selected operation. Latency is modelled by the sequencer only.
module md_compute
    import md_defs::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  md_op_e      md_op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic        sgn;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Product via extended operands; the low 64 bits of the product of two
    // sign-extended values equal the signed product. Division on magnitudes,
    // then sign fix-up: quotient truncates toward zero, remainder follows A.
    // 0x80000000 / -1 falls out naturally as 0x80000000 remainder 0.
    always_comb begin
        sgn   = is_signed_op(md_op);
        a_ext = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        b_ext = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        prod  = a_ext * b_ext;

        a_neg = sgn & a[31];
        b_neg = sgn & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
        // Keep the divider defined on B==0; the result is discarded anyway.
        den   = (b == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / den;
        r_mag = a_mag % den;
        quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem   = a_neg ? (32'd0 - r_mag) : r_mag;

        div_by_zero = is_div_op(md_op) && (b == 32'd0);

        if (is_div_op(md_op)) begin
            res_hi = rem;
            res_lo = quot;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the E stage.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | accepts start / mthi / mtlo; busy=0
//   ST_RUN  | result latched, counting down latency; HI/LO held; busy=1
//
// The result is computed on the start edge and parked in res_hi/res_lo;
// HI/LO only change on the final RUN edge so stalled readers never observe
// an intermediate value.
module mult_div_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      res_hi_q, res_hi_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic             dbz_q, dbz_d;

    logic [31:0]      comp_hi;
    logic [31:0]      comp_lo;
    logic             comp_dbz;

    md_compute u_compute (
        .a           (md.A),
        .b           (md.B),
        .md_op       (md.md_op),
        .res_hi      (comp_hi),
        .res_lo      (comp_lo),
        .div_by_zero (comp_dbz)
    );

    // Next-state: start beats mthi/mtlo in IDLE; all commands ignored in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (md.start) begin
                    res_hi_d = comp_hi;
                    res_lo_d = comp_lo;
                    dbz_d    = comp_dbz;
                    cnt_d    = is_div_op(md.md_op) ? DIV_LOAD : MULT_LOAD;
                    state_d  = ST_RUN;
                    busy_d   = 1'b1;
                end else begin
                    if (md.wr_hi) hi_d = md.A;
                    if (md.wr_lo) lo_d = md.A;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    // A divide by zero retires without touching HI/LO.
                    if (!dbz_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and data registers; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign md.busy = busy_q;
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage HI/LO multiply/divide unit for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu, plus mthi/mtlo direct writes, from the E stage using forwarded rs/rt operands.
- Holds HI/LO and signals busy. The hazard unit combines busy with start to stall D-stage HI/LO-using instructions (mult*, div*, mfhi, mflo, mthi, mtlo).

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage instruction is mult/multu/div/divu; valid for one cycle.
- md_op  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu. Sampled only when start=1.
- wr_hi  in  1  E-stage mthi: write A to HI.
- wr_lo  in  1  E-stage mtlo: write A to LO.
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- busy  out  1  operation in progress.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset: at any clk edge with reset=1, HI=0, LO=0, busy=0, counter=0, state=IDLE. An in-flight operation is aborted and its result discarded.
- States: IDLE and RUN. busy is a register: 1 exactly while state=RUN.
- Start in IDLE:
  - At the edge with start=1, latch the result computed from A, B and md_op into res_hi/res_lo.
  - Load counter with N-1, where N=MULT_CYCLES or DIV_CYCLES. Go to RUN.
- Timing: if start is sampled in cycle t, busy=1 in cycles t+1..t+N. At the edge ending cycle t+N, HI/LO take res_hi/res_lo, busy returns to 0, and state returns to IDLE. New HI/LO are visible from cycle t+N+1.
- RUN: the counter decrements each edge. The transition to IDLE occurs on the edge where counter==0.
- HI/LO hold their old values throughout RUN. A reader stalled by the hazard unit therefore never sees partial results.
- mult: signed 32x32 -> 64 bit product; HI=[63:32], LO=[31:0].
- multu: the same with unsigned operands.
- div:
  - Signed division. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend (A).
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned division; LO=quotient, HI=remainder.
- Divide by zero (B==0, div or divu): the unit still goes busy for DIV_CYCLES cycles, then HI/LO are left unchanged.
- wr_hi / wr_lo in IDLE:
  - HI (resp. LO) takes A at the next edge, with no busy.
  - Both asserted together write A to both registers.
- Simultaneous commands in IDLE: if start and wr_hi/wr_lo are both 1, start takes priority and the writes are ignored. This cannot occur with a single E-stage instruction.
- Commands in RUN: start, wr_hi and wr_lo are ignored. The hazard unit guarantees they do not arrive; the bench asserts this.
- Reset with start in the same cycle: reset wins, and the unit stays IDLE.
- The back-to-back start sampled in the cycle busy falls (state=IDLE again) is accepted.
- Width rule: results are computed in 64-bit sign- or zero-extended arithmetic. No saturation.

Decomposition:
- Shared package md_defs:
  - md_op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - Default cycle counts.
  - Opcode/funct constants for mult(011000), multu(011001), div(011010), divu(011011), mfhi(010000), mflo(010010), mthi(010001), mtlo(010011), shared with the hazard-detection block for its md-stall term.
- One sub-module, md_compute: purely combinational. Maps A, B, md_op to res_hi/res_lo/div_by_zero. The top level holds the FSM, counter and HI/LO registers.

Test Plan:
- mult: A=0xFFFFFFFE(-2), B=3, start at cycle 0 -> busy=1 in cycles 1-5; HI=0xFFFFFFFF, LO=0xFFFFFFFA from cycle 6.
- multu and divu:
  - multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
  - Then divu with A=100, B=7 -> busy in cycles 1-10; LO=14, HI=2.
- div sign/overflow cases:
  - A=-7, B=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1).
  - A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero and direct writes:
  - mthi 0x12345678 and mtlo 0x9ABCDEF0 -> visible the next cycle.
  - div with B=0 -> 10 busy cycles, then HI/LO unchanged.
- Reset mid-operation: start div, assert reset in busy cycle 4 -> next cycle busy=0, HI=LO=0. A subsequent mult still completes correctly.
- start asserted during RUN and wr_lo during RUN -> ignored; HI/LO equal the original operation's result.
